// File: rtl/csr_access_unit_pkg.sv
// csr_access_unit_pkg: shared widths, Zicsr funct3 encodings and FSM states for the CSR access unit
package csr_access_unit_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int CSR_ADDR_WIDTH = 12;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;
  localparam logic [2:0] CSRRW = 3'b001;
  localparam logic [2:0] CSRRS = 3'b010;
  localparam logic [2:0] CSRRC = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WRITE = 2'd2,
    RESP = 2'd3
  } state_t;
endpackage

// File: rtl/csr_access_unit_alu.sv
// csr_alu: read-modify-write value and write-required flag for a Zicsr instruction
module csr_alu
  import csr_access_unit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_op,
  input  logic [2:0]            i_funct3,
  input  logic [4:0]            i_rs1_idx,
  output logic [DATA_WIDTH-1:0] o_new,
  output logic                  o_wr_req
);
  always_comb begin
    o_new = (i_funct3[1:0] == 2'b01) ? i_op :
            (i_funct3[1:0] == 2'b10) ? (i_old | i_op) :
            (i_funct3[1:0] == 2'b11) ? (i_old & ~i_op) : ZERO;
    // set/clear with rs1 (or uimm) index 0 is a pure read
    o_wr_req = (i_funct3[1:0] == 2'b01) ? WRITE_ENABLE :
               (i_funct3[1:0] == 2'b00) ? 1'b0 : (i_rs1_idx != 5'd0);
  end
endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: executes Zicsr instructions against the CSR file (read, modify, write, respond)
// Optional CSR_RO_CHECK_EN: writes to read-only CSRs (addr[11:10]==2'b11) raise illegal-instruction
module csr_access_unit
  import csr_access_unit_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [2:0]                req_funct3_i,
  input  logic [CSR_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_rs1_data_i,
  input  logic [4:0]                req_rs1_idx_i,
  input  logic [4:0]                req_rd_idx_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
  input  logic [DATA_WIDTH-1:0]     csr_rdata_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      csr_instret_incr_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_rd_we_o,
  output logic [4:0]                rsp_rd_idx_o,
  output logic [DATA_WIDTH-1:0]     rsp_rd_data_o,
  output logic                      rsp_illegal_o
);
  state_t r_state, w_next;
  logic [2:0]                r_funct3;
  logic [CSR_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_op, r_old, r_new;
  logic [4:0]                r_rs1_idx, r_rd_idx;
  logic                      r_wr, r_illegal;
  logic [DATA_WIDTH-1:0]     w_new;
  logic                      w_wr_req, w_illegal;

  csr_alu u_alu (
    .i_old     (csr_rdata_i),
    .i_op      (r_op),
    .i_funct3  (r_funct3),
    .i_rs1_idx (r_rs1_idx),
    .o_new     (w_new),
    .o_wr_req  (w_wr_req)
  );

`ifdef CSR_RO_CHECK_EN
  assign w_illegal = (r_funct3[1:0] == 2'b00) || (w_wr_req && r_addr[11:10] == 2'b11);
`else
  assign w_illegal = (r_funct3[1:0] == 2'b00);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = req_valid_i ? READ : IDLE;
      READ:  w_next = WRITE;
      WRITE: w_next = rsp_ready_i ? IDLE : RESP;
      RESP:  w_next = rsp_ready_i ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_funct3 <= '0;
      r_addr <= '0;
      r_op <= '0;
      r_rs1_idx <= '0;
      r_rd_idx <= '0;
      r_old <= '0;
      r_new <= '0;
      r_wr <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == IDLE && req_valid_i) begin
      r_funct3 <= req_funct3_i;
      r_addr <= req_addr_i;
      r_op <= req_funct3_i[2] ? {{(DATA_WIDTH-5){1'b0}}, req_rs1_idx_i} : req_rs1_data_i;
      r_rs1_idx <= req_rs1_idx_i;
      r_rd_idx <= req_rd_idx_i;
    end else if (r_state == READ) begin
      r_old <= w_illegal ? ZERO : csr_rdata_i;
      r_new <= w_new;
      r_wr <= w_wr_req && !w_illegal;
      r_illegal <= w_illegal;
    end
  end

  // write and retire strobes are masked while reset is held so nothing leaks mid-operation
  always_comb begin
    req_ready_o = (r_state == IDLE);
    rsp_valid_o = (r_state == WRITE) || (r_state == RESP);
    csr_raddr_o = (r_state == READ) ? r_addr : '0;
    csr_we_o = rst_i && (r_state == WRITE) && r_wr;
    csr_waddr_o = csr_we_o ? r_addr : '0;
    csr_wdata_o = csr_we_o ? r_new : ZERO;
    rsp_illegal_o = rsp_valid_o && r_illegal;
    rsp_rd_we_o = rsp_valid_o && !r_illegal && (r_rd_idx != 5'd0);
    rsp_rd_idx_o = rsp_valid_o ? r_rd_idx : 5'd0;
    rsp_rd_data_o = rsp_valid_o ? r_old : ZERO;
    csr_instret_incr_o = rst_i && rsp_valid_o && rsp_ready_i && !r_illegal;
  end
endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Executes Zicsr instructions against the CSR file: accepts a decoded CSR request from the execute stage, drives the CSR file read port, computes the read-modify-write value, then drives the CSR file write port and returns the old CSR value for the register-file writeback. It is the initiator side of the CSR file's read/write/instret interface and sits between the execute stage and writeback.

## Interface
- DATA_WIDTH, 32, CSR data and rs1 width
- CSR_ADDR_WIDTH, 12, CSR address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- req_valid_i  in  1  CSR request valid
- req_ready_o  out  1  unit can accept a request
- req_funct3_i  in  3  Zicsr funct3
- req_addr_i  in  CSR_ADDR_WIDTH  CSR address
- req_rs1_data_i  in  DATA_WIDTH  rs1 value (register forms)
- req_rs1_idx_i  in  5  rs1 index; uimm for immediate forms
- req_rd_idx_i  in  5  destination register
- csr_raddr_o  out  CSR_ADDR_WIDTH  CSR file read address
- csr_rdata_i  in  DATA_WIDTH  CSR file read data (combinational)
- csr_we_o  out  1  CSR file write enable
- csr_waddr_o  out  CSR_ADDR_WIDTH  CSR file write address
- csr_wdata_o  out  DATA_WIDTH  CSR file write data
- csr_instret_incr_o  out  1  retire pulse to minstret
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  writeback accepts response
- rsp_rd_we_o  out  1  write rd
- rsp_rd_idx_o  out  5  rd index
- rsp_rd_data_o  out  DATA_WIDTH  old CSR value
- rsp_illegal_o  out  1  illegal-instruction exception

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready_o=1; on req_valid_i latch funct3, addr, operand, rs1_idx, rd_idx; go READ.
- READ: csr_raddr_o = latched addr; capture csr_rdata_i as old; compute new; go WRITE.
- Operand: funct3[2]=0 uses rs1 data; funct3[2]=1 uses zero-extended 5-bit uimm.
- funct3 001/101: new=op, write always. 010/110: new=old|op. 011/111: new=old&~op. Set/clear write only if rs1_idx≠0.
- funct3 000 or 100: illegal.
- WRITE: csr_we_o=1 for exactly this cycle if write required and not illegal; waddr/wdata = latched addr/new. rsp_valid_o=1. If rsp_ready_i, go IDLE, else RESP.
- RESP: hold rsp_valid_o and all rsp_* stable until rsp_ready_i; then IDLE. csr_we_o=0.
- rsp_rd_we_o = !illegal && rd_idx≠0. rsp_rd_data_o = old (0 when illegal).
- csr_instret_incr_o pulses one cycle on the response handshake, only if !illegal.

## Timing
- Request accepted cycle N; CSR read N+1; CSR write and first rsp_valid_o N+2. Minimum 3 cycles per instruction; back-to-back accept at N+3.
- req_ready_o=0 in READ/WRITE/RESP; no request is dropped.
- Reset values: req_ready_o=1 (after reset), all other outputs 0, state IDLE.
- Reset asserted mid-operation: FSM to IDLE next edge; pending write discarded; no instret pulse.
- csr_raddr_o is 0 outside READ; csr_waddr_o/csr_wdata_o are 0 when csr_we_o=0.

## Configuration
- CSR_RO_CHECK_EN defined: a required write to an address with addr[11:10]==2'b11 (read-only) raises rsp_illegal_o, suppresses csr_we_o, rd write and instret. Read-only reads (no write required) stay legal.
- Undefined: no read-only check; the write is issued and the CSR file ignores it; illegal only for funct3 000/100.

## Structure
- Shared defines header: funct3 encodings (CSRRW…CSRRCI), FSM state encodings, CSR_ADDR_WIDTH, DATA_WIDTH, WRITE_ENABLE, ZERO.
- Sub-module csr_alu: combinational old/op/funct3 → new value and write-required flag.

## Test plan
- CSRRW addr 0x340, rs1=0xDEADBEEF, rd=5, old=0x12345678 → N+2: csr_we_o=1, wdata 0xDEADBEEF; rsp_rd_data_o=0x12345678, rsp_rd_we_o=1.
- CSRRS rs1_idx=0 on 0x300 → csr_we_o stays 0; rd gets old; instret pulse on handshake.
- CSRRCI uimm=0x3 on old 0x0000000F → wdata 0x0000000C.
- rsp_ready_i low 4 cycles → rsp_* stable, csr_we_o high exactly one cycle, req_ready_o=0 throughout.
- With CSR_RO_CHECK_EN: CSRRW on 0xC00 → rsp_illegal_o=1, no write, no instret; CSRRS rs1_idx=0 on 0xC00 → legal.
- rst_i low during READ → next cycle IDLE, all outputs 0, no write issued.
